mem_bus_target: RTL and testbench
=================================

// Module: mem_bus_target
// PURPOSE
//  Memory-side responder on the CPU external memory bus: decodes the 16-bit address driven by the
//  core, services one read or write per request from an internal synchronous RAM window, and
//  inserts a programmable number of wait states via mem_wait_n. Used as on-chip RAM and as the
//  bus model for core-level simulation.
// PARAMETERS
//  ADDR_WIDTH   10       RAM window size = 2**ADDR_WIDTH bytes
//  BASE_ADDR    16'h8000 window base; must be a multiple of 2**ADDR_WIDTH
//  WAIT_STATES  2        wait cycles inserted per access, 0..15
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  reset_n      in   1   asynchronous reset, active-low
//  mem_addr     in   16  address from core
//  mem_mreq_n   in   1   memory request, active-low
//  mem_rd_n     in   1   read strobe, active-low
//  mem_wr_n     in   1   write strobe, active-low
//  mem_dout     in   8   write data from core
//  mem_din      out  8   read data to core
//  mem_wait_n   out  1   wait request to core, active-low
//  mem_sel      out  1   high while an in-window access is being serviced
//  bus_err      out  1   one-cycle pulse on illegal request (rd_n and wr_n both low)
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE, wait counter 0, mem_din 8'hFF, mem_wait_n 1, mem_sel 0,
//   bus_err 0. RAM contents not reset.
//  Decode: hit = mem_addr[15:ADDR_WIDTH] == BASE_ADDR[15:ADDR_WIDTH]; offset = mem_addr[ADDR_WIDTH-1:0].
//  FSM states IDLE, WAIT, RESP, DONE:
//   IDLE: at an edge with mreq_n=0, hit, and exactly one of rd_n/wr_n low -> latch offset,
//    direction, mem_dout; mem_sel<=1; if WAIT_STATES=0 go RESP, else cnt<=WAIT_STATES-1,
//    mem_wait_n<=0, go WAIT.
//    mreq_n=0 with rd_n=0 and wr_n=0 (any address) -> bus_err<=1 for one cycle, stay IDLE.
//    mreq_n=0 with miss, or no strobe -> ignore, stay IDLE; mem_din unchanged.
//   WAIT: mem_wait_n held 0; cnt decrements each cycle; at cnt=0 mem_wait_n<=1, go RESP.
//    mreq_n sampled 1 in WAIT -> abort: no RAM write, mem_wait_n<=1, mem_sel<=0, go IDLE.
//   RESP: read -> mem_din<=ram[offset]; write -> ram[offset]<=latched data. Go DONE.
//   DONE: hold mem_din; when mreq_n sampled 1 -> mem_sel<=0, go IDLE. Exactly one access per
//    mreq_n low period; a held request never repeats.
//  Latency: request sampled at edge E; mem_wait_n low on edges E..E+W-1 (W=WAIT_STATES);
//   read data valid on mem_din after edge E+W+1 and held until the next completed read.
//  Write data/address are taken at E; later changes of mem_dout/mem_addr during the access are ignored.
//  Strobe changes during WAIT/RESP/DONE are ignored; only mreq_n deassertion ends the cycle.
//  Offset wraps naturally within the window; no access outside it reaches RAM.
//  reset_n low mid-access: immediate return to reset values, pending write discarded.
// TESTING
//  W=2: write 8'hA5 to 16'h8010, then read 16'h8010 -> mem_wait_n low exactly 2 cycles each,
//   mem_din=8'hA5 after edge E+3.
//  W=0 via override: read 16'h83FF -> no wait_n low, data valid after E+1; mem_sel high until mreq_n rises.
//  Read 16'h4000 (miss) -> mem_wait_n stays 1, mem_sel 0, mem_din unchanged.
//  mreq_n=0, rd_n=0, wr_n=0 -> bus_err high exactly 1 cycle, RAM unchanged, state IDLE.
//  Write 8'h3C to 16'h8020 with mreq_n raised after 1 wait cycle -> abort; later read returns
//   previous contents.
//  Assert reset_n=0 during WAIT of a write -> mem_wait_n=1, mem_din=8'hFF, mem_sel=0 at once;
//   target byte unchanged.

Source files
------------

// File: rtl/mem_bus_target.sv
// rtl/mem_bus_target.sv - memory-bus responder with RAM window and programmable wait states
module mem_bus_target #(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [15:0] BASE_ADDR   = 16'h8000,
  parameter int          WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] mem_addr,
  input  logic        mem_mreq_n,
  input  logic        mem_rd_n,
  input  logic        mem_wr_n,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        mem_wait_n,
  output logic        mem_sel,
  output logic        bus_err
);
  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  // Counter preload is W-1 so mem_wait_n stays low for exactly W edges.
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_DONE} state_t;

  state_t                state;
  state_t                state_next;
  logic [3:0]            cnt;
  logic [3:0]            cnt_next;
  logic                  wait_n_next;
  logic                  sel_next;
  logic                  err_next;
  logic                  capture;
  logic                  ram_we;
  logic                  ram_re;
  logic [ADDR_WIDTH-1:0] off_q;
  logic                  is_read_q;
  logic [7:0]            wdata_q;
  logic [7:0]            ram [DEPTH];
  logic                  hit;
  logic                  one_strobe;

  assign hit        = (mem_addr[15:ADDR_WIDTH] == BASE_ADDR[15:ADDR_WIDTH]);
  assign one_strobe = mem_rd_n ^ mem_wr_n;
  assign ram_we     = (state == S_RESP) && !is_read_q;
  assign ram_re     = (state == S_RESP) && is_read_q;

  // Next-state and registered-output decisions for the bus handshake.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    wait_n_next = mem_wait_n;
    sel_next    = mem_sel;
    err_next    = 1'b0;
    capture     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!mem_mreq_n) begin
          if (!mem_rd_n && !mem_wr_n) begin
            err_next = 1'b1;
          end else if (hit && one_strobe) begin
            capture  = 1'b1;
            sel_next = 1'b1;
            if (WAIT_STATES == 0) begin
              state_next = S_RESP;
            end else begin
              cnt_next    = CNT_INIT;
              wait_n_next = 1'b0;
              state_next  = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (mem_mreq_n) begin
          wait_n_next = 1'b1;
          sel_next    = 1'b0;
          state_next  = S_IDLE;
        end else if (cnt == 4'd0) begin
          wait_n_next = 1'b1;
          state_next  = S_RESP;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      S_RESP: begin
        state_next = S_DONE;
      end
      S_DONE: begin
        if (mem_mreq_n) begin
          sel_next   = 1'b0;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register and handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      mem_wait_n <= 1'b1;
      mem_sel    <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      mem_wait_n <= wait_n_next;
      mem_sel    <= sel_next;
      bus_err    <= err_next;
    end
  end

  // Request capture at acceptance and read-data return in RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      off_q     <= '0;
      is_read_q <= 1'b0;
      wdata_q   <= 8'h00;
      mem_din   <= 8'hFF;
    end else begin
      if (capture) begin
        off_q     <= mem_addr[ADDR_WIDTH-1:0];
        is_read_q <= !mem_rd_n;
        wdata_q   <= mem_dout;
      end
      if (ram_re) begin
        mem_din <= ram[off_q];
      end
    end
  end

  // RAM array is not reset; a write only lands from RESP, so reset discards it.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[off_q] <= wdata_q;
    end
  end
endmodule

// File: tb/tb_mem_bus_target.sv
// tb/tb_mem_bus_target.sv - scoreboard bench for mem_bus_target with W=0 and W=2 instances
module tb_mem_bus_target;
  typedef struct {
    int         kind;   // 0 read, 1 write, 2 aborted, 3 bus error
    logic [7:0] din;
    int         waits;
    int         selc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] mem_addr;
  logic        mem_rd_n;
  logic        mem_wr_n;
  logic [7:0]  mem_dout;
  logic        mreq0;
  logic        mreq1;
  logic [7:0]  din0;
  logic [7:0]  din1;
  logic        wn0;
  logic        wn1;
  logic        sel0;
  logic        sel1;
  logic        err0;
  logic        err1;

  int n_pass  = 0;
  int n_total = 0;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] mem_m [2][1024];
  logic [7:0] last_din [2];
  int         sc [2] = '{0, 0};
  int         wc [2] = '{0, 0};
  int         ec [2] = '{0, 0};
  bit         psel [2] = '{0, 0};
  bit         perr [2] = '{0, 0};
  logic [15:0] pool [6] = '{16'h8000, 16'h8010, 16'h8020, 16'h83FF, 16'h8155, 16'h82AA};
  logic [15:0] miss [5] = '{16'h4000, 16'h8400, 16'h7FFF, 16'h0010, 16'hC010};

  always #5 clk = ~clk;

  mem_bus_target #(.WAIT_STATES(0)) dut_w0 (
    .clk(clk), .reset_n(reset_n), .mem_addr(mem_addr), .mem_mreq_n(mreq0),
    .mem_rd_n(mem_rd_n), .mem_wr_n(mem_wr_n), .mem_dout(mem_dout),
    .mem_din(din0), .mem_wait_n(wn0), .mem_sel(sel0), .bus_err(err0)
  );

  mem_bus_target dut_w2 (
    .clk(clk), .reset_n(reset_n), .mem_addr(mem_addr), .mem_mreq_n(mreq1),
    .mem_rd_n(mem_rd_n), .mem_wr_n(mem_wr_n), .mem_dout(mem_dout),
    .mem_din(din1), .mem_wait_n(wn1), .mem_sel(sel1), .bus_err(err1)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic push(input int i, input exp_t e);
    if (i == 1) q1.push_back(e);
    else q0.push_back(e);
  endtask

  task automatic pop(input int i, output bit ok, output exp_t e);
    ok = 1'b1;
    if (i == 1 && q1.size() > 0) e = q1.pop_front();
    else if (i == 0 && q0.size() > 0) e = q0.pop_front();
    else begin
      ok = 1'b0;
      n_total++;
      $display("FAIL unexpected_response dut%0d: activity with empty scoreboard", i);
    end
  endtask

  function automatic logic cur_wn(input int i);
    return (i == 1) ? wn1 : wn0;
  endfunction
  function automatic logic cur_sel(input int i);
    return (i == 1) ? sel1 : sel0;
  endfunction
  function automatic logic [7:0] cur_din(input int i);
    return (i == 1) ? din1 : din0;
  endfunction

  task automatic set_mreq(input int i, input logic v);
    if (i == 1) mreq1 = v;
    else mreq0 = v;
  endtask

  task automatic idle_bus();
    mreq0    = 1'b1;
    mreq1    = 1'b1;
    mem_rd_n = 1'b1;
    mem_wr_n = 1'b1;
    mem_addr = 16'($urandom);
    mem_dout = 8'($urandom);
  endtask

  // Monitor: one access ends when mem_sel falls, one error when bus_err falls.
  task automatic mon_step(input int i, input logic sel, input logic wn, input logic err,
                          input logic [7:0] din);
    exp_t e;
    bit   ok;
    if (sel) begin
      sc[i]++;
      if (!wn) wc[i]++;
    end
    if (err) ec[i]++;
    if (psel[i] && !sel) begin
      pop(i, ok, e);
      if (ok) begin
        chk($sformatf("kind_dut%0d", i), (e.kind == 3) ? 3 : 0, 0);
        chk($sformatf("wait_cycles_dut%0d", i), wc[i], e.waits);
        chk($sformatf("sel_cycles_dut%0d", i), sc[i], e.selc);
        chk($sformatf("mem_din_dut%0d", i), int'(din), int'(e.din));
      end
      sc[i] = 0;
      wc[i] = 0;
    end
    if (perr[i] && !err) begin
      pop(i, ok, e);
      if (ok) begin
        chk($sformatf("err_kind_dut%0d", i), e.kind, 3);
        chk($sformatf("err_len_dut%0d", i), ec[i], 1);
      end
      ec[i] = 0;
    end
    psel[i] = sel;
    perr[i] = err;
  endtask

  // Sample on the falling edge, half a cycle away from the DUT's active edge.
  always @(negedge clk) begin
    mon_step(0, sel0, wn0, err0, din0);
    mon_step(1, sel1, wn1, err1, din1);
  end

  // One bus access held for W+1 edges after acceptance, then released.
  task automatic do_access(input int i, input logic [15:0] a, input bit rd, input logic [7:0] data);
    exp_t e;
    int   w;
    bit   hit;
    bit   bad;
    int   off;
    w   = (i == 1) ? 2 : 0;
    hit = (a[15:10] == 6'b100000);
    off = int'(a[9:0]);
    if (hit) begin
      if (rd) last_din[i] = mem_m[i][off];
      else mem_m[i][off] = data;
      e.kind  = rd ? 0 : 1;
      e.din   = last_din[i];
      e.waits = w;
      e.selc  = w + 2;
      push(i, e);
    end
    @(negedge clk);
    mem_addr = a;
    mem_rd_n = !rd;
    mem_wr_n = rd;
    mem_dout = data;
    set_mreq(i, 1'b0);
    bad = 1'b0;
    @(posedge clk);
    repeat (w + 1) begin
      @(negedge clk);
      if (hit) begin
        mem_addr = 16'($urandom);
        mem_dout = 8'($urandom);
        {mem_rd_n, mem_wr_n} = 2'($urandom);
      end else if (cur_wn(i) == 1'b0 || cur_sel(i) == 1'b1) begin
        bad = 1'b1;
      end
      @(posedge clk);
    end
    @(negedge clk);
    idle_bus();
    if (!hit) begin
      chk($sformatf("miss_idle_dut%0d", i), int'(bad), 0);
      chk($sformatf("miss_din_dut%0d", i), int'(cur_din(i)), int'(last_din[i]));
    end
  endtask

  task automatic do_err(input int i);
    exp_t e;
    e.kind = 3; e.din = 8'h00; e.waits = 0; e.selc = 0;
    push(i, e);
    @(negedge clk);
    mem_addr = 16'($urandom);
    mem_rd_n = 1'b0;
    mem_wr_n = 1'b0;
    set_mreq(i, 1'b0);
    @(posedge clk);
    @(negedge clk);
    idle_bus();
  endtask

  // Write on the W=2 instance abandoned after one wait cycle.
  task automatic do_abort(input logic [15:0] a, input logic [7:0] data);
    exp_t e;
    e.kind = 2; e.din = last_din[1]; e.waits = 1; e.selc = 1;
    push(1, e);
    @(negedge clk);
    mem_addr = a;
    mem_rd_n = 1'b1;
    mem_wr_n = 1'b0;
    mem_dout = data;
    mreq1    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    idle_bus();
    @(posedge clk);
  endtask

  task automatic do_reset_mid();
    exp_t e;
    e.kind = 2; e.din = 8'hFF; e.waits = 1; e.selc = 1;
    push(1, e);
    @(negedge clk);
    mem_addr = 16'h8010;
    mem_rd_n = 1'b1;
    mem_wr_n = 1'b0;
    mem_dout = 8'h5A;
    mreq1    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_wait_n", int'(wn1), 1);
    chk("rst_mid_din", int'(din1), 8'hFF);
    chk("rst_mid_sel", int'(sel1), 0);
    chk("rst_mid_din_w0", int'(din0), 8'hFF);
    last_din[0] = 8'hFF;
    last_din[1] = 8'hFF;
    @(negedge clk);
    idle_bus();
    reset_n = 1'b1;
  endtask

  initial begin
    int i;
    int r;
    reset_n     = 1'b0;
    last_din[0] = 8'hFF;
    last_din[1] = 8'hFF;
    idle_bus();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_din_w0", int'(din0), 8'hFF);
    chk("reset_wait_n_w0", int'(wn0), 1);
    chk("reset_sel_w0", int'(sel0), 0);
    chk("reset_err_w0", int'(err0), 0);
    chk("reset_din_w2", int'(din1), 8'hFF);
    chk("reset_wait_n_w2", int'(wn1), 1);
    chk("reset_sel_w2", int'(sel1), 0);
    chk("reset_err_w2", int'(err1), 0);
    reset_n = 1'b1;

    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 6; k++)
        do_access(d, pool[k], 1'b0, 8'($urandom));

    do_access(1, 16'h8010, 1'b0, 8'hA5);
    do_access(1, 16'h8010, 1'b1, 8'h00);
    do_access(0, 16'h83FF, 1'b1, 8'h00);
    do_access(1, 16'h4000, 1'b1, 8'h00);
    do_err(1);
    do_err(0);
    do_abort(16'h8020, 8'h3C);
    do_access(1, 16'h8020, 1'b1, 8'h00);
    do_reset_mid();
    do_access(1, 16'h8010, 1'b1, 8'h00);

    repeat (80) begin
      i = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      if (r < 4) do_access(i, pool[$urandom_range(0, 5)], 1'b1, 8'h00);
      else if (r < 7) do_access(i, pool[$urandom_range(0, 5)], 1'b0, 8'($urandom));
      else if (r < 8) do_access(i, miss[$urandom_range(0, 4)], 1'($urandom), 8'($urandom));
      else if (r < 9) do_err(i);
      else if (i == 1) do_abort(pool[$urandom_range(0, 5)], 8'($urandom));
      else do_access(i, pool[$urandom_range(0, 5)], 1'b1, 8'h00);
    end

    repeat (5) @(negedge clk);
    chk("pending_dut0", q0.size(), 0);
    chk("pending_dut2", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
